// File: rtl/snake_body_stack.sv
// LIFO of snake-body positions; the registered top-of-stack is always presented on posSal.
// Optional sticky error flag output enabled by defining BODY_STACK_ERR_FLAGS_EN.
module snake_body_stack #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] posEnt,
   input  logic             push,
   input  logic             pop,
   output logic [WIDTH-1:0] posSal,
   output logic             full,
   output logic             empty,
   output logic [PW-1:0]    count
`ifdef BODY_STACK_ERR_FLAGS_EN
   ,
   output logic             err
`endif
);

   logic [PW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] pos_sal_q, pos_sal_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic             full_w, empty_w;
   logic             wr_en;
   logic [PW-1:0]    wr_idx;
   logic [PW-1:0]    below_idx;
   logic [WIDTH-1:0] below_val;

   assign full_w  = (ptr_q == PW'(DEPTH));
   assign empty_w = (ptr_q == '0);

   // Entry just under the current top; becomes the new top on a pop.
   always_comb begin
      below_idx = ptr_q - PW'(2);
      below_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (below_idx == PW'(i)) below_val = mem_q[i];
      end
   end

   always_comb begin
      ptr_d     = ptr_q;
      pos_sal_d = pos_sal_q;
      wr_en     = 1'b0;
      wr_idx    = ptr_q;
      unique case ({push, pop})
         2'b10: begin
            if (!full_w) begin
               wr_en     = 1'b1;
               ptr_d     = ptr_q + PW'(1);
               pos_sal_d = posEnt;
            end
         end
         2'b01: begin
            if (ptr_q == PW'(1)) begin
               ptr_d     = '0;
               pos_sal_d = '0;
            end else if (!empty_w) begin
               ptr_d     = ptr_q - PW'(1);
               pos_sal_d = below_val;
            end
         end
         2'b11: begin
            // Simultaneous push/pop replaces the top; on an empty stack it is a plain push.
            wr_en     = 1'b1;
            pos_sal_d = posEnt;
            if (empty_w) begin
               ptr_d = PW'(1);
            end else begin
               wr_idx = ptr_q - PW'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (wr_en && (wr_idx == PW'(i))) mem_d[i] = posEnt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q     <= '0;
         pos_sal_q <= '0;
      end else begin
         ptr_q     <= ptr_d;
         pos_sal_q <= pos_sal_d;
      end
   end

   // Storage contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

`ifdef BODY_STACK_ERR_FLAGS_EN
   logic err_q, err_d;
   logic illegal;

   assign illegal = (push & ~pop & full_w) | (pop & ~push & empty_w);
   assign err_d   = err_q | illegal;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

   assign posSal = pos_sal_q;
   assign full   = full_w;
   assign empty  = empty_w;
   assign count  = ptr_q;

endmodule

// File: tb/tb_snake_body_stack.sv
// Directed scoreboard bench for snake_body_stack; a queue-based LIFO model predicts each edge.
// Checks err as well when BODY_STACK_ERR_FLAGS_EN is defined.
module tb_snake_body_stack;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] posEnt;
   logic       push;
   logic       pop;
   logic [2:0] posSal;
   logic       full;
   logic       empty;
   logic [3:0] count;
`ifdef BODY_STACK_ERR_FLAGS_EN
   logic       err;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] pos;
      logic [3:0] cnt;
      logic       full;
      logic       empty;
      logic       err;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] model[$];
   logic       model_err = 1'b0;

   snake_body_stack #(.WIDTH(3), .DEPTH(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .posEnt (posEnt),
      .push   (push),
      .pop    (pop),
      .posSal (posSal),
      .full   (full),
      .empty  (empty),
      .count  (count)
`ifdef BODY_STACK_ERR_FLAGS_EN
      ,
      .err    (err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model_state();
      exp_t e;
      e.pos   = (model.size() == 0) ? 3'd0 : model[model.size() - 1];
      e.cnt   = 4'(model.size());
      e.full  = (model.size() == 8);
      e.empty = (model.size() == 0);
      e.err   = model_err;
      return e;
   endfunction

   // Drive one edge's request, predict into the scoreboard, then compare after the edge.
   task automatic step(input string tag, input logic pu, input logic po, input logic [2:0] d);
      exp_t e;
      push   = pu;
      pop    = po;
      posEnt = d;
      if (pu && po) begin
         if (model.size() == 0) model.push_back(d);
         else model[model.size() - 1] = d;
      end else if (pu) begin
         if (model.size() < 8) model.push_back(d);
         else model_err = 1'b1;
      end else if (po) begin
         if (model.size() > 0) void'(model.pop_back());
         else model_err = 1'b1;
      end
      sb.push_back(model_state());
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
      if (sb.size() == 0) begin
         check({tag, " sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         check({tag, " posSal"}, 32'(posSal), 32'(e.pos));
         check({tag, " count"}, 32'(count), 32'(e.cnt));
         check({tag, " full"}, 32'(full), 32'(e.full));
         check({tag, " empty"}, 32'(empty), 32'(e.empty));
`ifdef BODY_STACK_ERR_FLAGS_EN
         check({tag, " err"}, 32'(err), 32'(e.err));
`endif
      end
   endtask

   initial begin
      reset  = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
      posEnt = 3'd0;
      #100;
      check("rst posSal", 32'(posSal), 0);
      check("rst count", 32'(count), 0);
      check("rst empty", 32'(empty), 1);
      check("rst full", 32'(full), 0);
`ifdef BODY_STACK_ERR_FLAGS_EN
      check("rst err", 32'(err), 0);
`endif
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Basic push/pop sequence
      step("push1", 1, 0, 3'd1);
      step("push2", 1, 0, 3'd2);
      step("push3", 1, 0, 3'd3);
      step("push2b", 1, 0, 3'd2);
      check("seq count4", 32'(count), 4);
      step("pop_a", 0, 1, 3'd0);
      check("seq pop posSal", 32'(posSal), 3);
      step("push1b", 1, 0, 3'd1);
      step("pop_b", 0, 1, 3'd0);
      check("seq end posSal", 32'(posSal), 3);
      check("seq end count", 32'(count), 3);
      step("hold", 0, 0, 3'd7);
      for (int i = 0; i < 3; i++) step("drain", 0, 1, 3'd0);

      // Fill to full, then overflow push
      for (int i = 1; i <= 8; i++) step("fill", 1, 0, 3'(i));
      check("full flag", 32'(full), 1);
      check("full posSal", 32'(posSal), 0);
      step("overflow", 1, 0, 3'd5);
      check("overflow count", 32'(count), 8);
      check("overflow posSal", 32'(posSal), 0);
      step("replace_full", 1, 1, 3'd4);
      for (int i = 0; i < 8; i++) step("unfill", 0, 1, 3'd0);

      // Underflow pop
      step("underflow", 0, 1, 3'd0);
      check("underflow empty", 32'(empty), 1);

      // Simultaneous push/pop
      step("pp_empty", 1, 1, 3'd3);
      step("pop_pp", 0, 1, 3'd0);
      step("s5_push1", 1, 0, 3'd1);
      step("s5_push2", 1, 0, 3'd2);
      step("s5_replace", 1, 1, 3'd6);
      check("replace count", 32'(count), 2);
      check("replace posSal", 32'(posSal), 6);
      step("s5_pop", 0, 1, 3'd0);
      check("after replace pop", 32'(posSal), 1);
      step("s5_pop2", 0, 1, 3'd0);

      // Asynchronous reset between edges
      step("r_push4", 1, 0, 3'd4);
      step("r_push5", 1, 0, 3'd5);
      #2;
      reset = 1'b0;
      #1;
      check("async posSal", 32'(posSal), 0);
      check("async count", 32'(count), 0);
      check("async empty", 32'(empty), 1);
`ifdef BODY_STACK_ERR_FLAGS_EN
      check("async err", 32'(err), 0);
`endif
      model.delete();
      model_err = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      step("post_rst_push", 1, 0, 3'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
